// File: rtl/behaviour_mode_ctrl.sv
// ---------------------------------------------------------------------------
// behaviour_mode_ctrl
//   Single-button user interface for the hexapod brain. The raw button is
//   synchronised and debounced. Each debounced press is then classed as short
//   or long. A short press advances the behaviour mode, but only while
//   behaviours are enabled. A long press toggles the global behaviour enable.
//
// Ports
//   clk       in   system clock
//   rstn      in   asynchronous active-low reset
//   btn       in   raw, bouncing, asynchronous push-button (1 = pressed)
//   mode      out  active behaviour mode (0 .. NMODES-1)
//   en        out  behaviour enable
//   mode_chg  out  one-cycle strobe, coincident with a new mode value
//   long_evt  out  one-cycle strobe, coincident with a new en value
//   pressed   out  debounced button level
// ---------------------------------------------------------------------------
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | button released, waiting for a debounced press
// ST_HELD   | press in progress, hold counter timing it against LONG_CYCLES
// ST_LONG   | long press already acted on, waiting for the release
// ---------------------------------------------------------------------------
module behaviour_mode_ctrl #(
    parameter int DEB_BITS    = 17,
    parameter int LONG_CYCLES = 12000000,
    parameter int NMODES      = 4,
    parameter int MODE_W      = 2,
    parameter int INI_MODE    = 0,
    parameter int INI_EN      = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              btn,
    output logic [MODE_W-1:0] mode,
    output logic              en,
    output logic              mode_chg,
    output logic              long_evt,
    output logic              pressed
);

    localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NMODES - 1);
    localparam logic [MODE_W-1:0] MODE_INIT = MODE_W'(INI_MODE);
    localparam logic              EN_INIT   = (INI_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    // synchroniser and debouncer
    logic                sync_a;
    logic                sync_b;
    logic                cap;
    logic [DEB_BITS-1:0] deb_cnt;
    logic                deb;

    // FSM
    state_t              state;
    state_t              state_nxt;
    logic [HOLD_W-1:0]   hold;
    logic [HOLD_W-1:0]   hold_nxt;
    logic [MODE_W-1:0]   mode_nxt;
    logic                en_nxt;
    logic                chg_nxt;
    logic                long_nxt;

    // The debounced level only follows the captured value after the captured
    // value has stayed put for 2^(DEB_BITS-1) cycles. Any change on the
    // synchronised input restarts that count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            cap     <= 1'b0;
            deb_cnt <= '0;
            deb     <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            if (sync_b != cap) begin
                cap     <= sync_b;
                deb_cnt <= '0;
            end else if (!deb_cnt[DEB_BITS-1]) begin
                deb_cnt <= deb_cnt + DEB_BITS'(1);
            end else begin
                deb <= cap;
            end
        end
    end

    assign pressed = deb;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            hold     <= '0;
            mode     <= MODE_INIT;
            en       <= EN_INIT;
            mode_chg <= 1'b0;
            long_evt <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            mode     <= mode_nxt;
            en       <= en_nxt;
            mode_chg <= chg_nxt;
            long_evt <= long_nxt;
        end
    end

    // IDLE is only entered when the level is low, and it leaves reset low.
    // A high level seen in IDLE is therefore always a fresh rising edge.
    // In HELD the release is tested first. A release seen in the same cycle
    // that the counter shows LONG_CYCLES-1 is still treated as a short press.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        mode_nxt  = mode;
        en_nxt    = en;
        chg_nxt   = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (deb) begin
                    state_nxt = ST_HELD;
                    hold_nxt  = '0;
                end
            end
            ST_HELD: begin
                if (!deb) begin
                    state_nxt = ST_IDLE;
                    if (en) begin
                        mode_nxt = (mode == MODE_LAST) ? '0 : mode + MODE_W'(1);
                        chg_nxt  = 1'b1;
                    end
                end else if (hold == HOLD_LAST) begin
                    state_nxt = ST_LONG;
                    en_nxt    = ~en;
                    long_nxt  = 1'b1;
                end else if (hold != HOLD_MAX) begin
                    hold_nxt = hold + HOLD_W'(1);
                end
            end
            ST_LONG: begin
                if (!deb) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_behaviour_mode_ctrl.sv
module tb_behaviour_mode_ctrl;

    localparam int DEB_BITS    = 4;
    localparam int LONG_CYCLES = 40;
    localparam int NMODES      = 3;
    localparam int MODE_W      = 2;
    localparam int INI_MODE    = 0;
    localparam int INI_EN      = 1;
    localparam int GAP         = 30;

    logic              clk;
    logic              rstn;
    logic              btn;
    logic [MODE_W-1:0] mode;
    logic              en;
    logic              mode_chg;
    logic              long_evt;
    logic              pressed;

    int checks;
    int errors;
    int cyc;
    int chg_cnt;
    int long_cnt;
    int press_cnt;
    int last_chg_cyc;
    int last_long_cyc;
    logic [MODE_W-1:0] prev_mode;
    logic              prev_en;
    logic              prev_pressed;

    behaviour_mode_ctrl #(
        .DEB_BITS   (DEB_BITS),
        .LONG_CYCLES(LONG_CYCLES),
        .NMODES     (NMODES),
        .MODE_W     (MODE_W),
        .INI_MODE   (INI_MODE),
        .INI_EN     (INI_EN)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .btn     (btn),
        .mode    (mode),
        .en      (en),
        .mode_chg(mode_chg),
        .long_evt(long_evt),
        .pressed (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Strobe bookkeeping, plus the rule that each strobe coincides with its
    // value change: mode moves exactly when mode_chg is high, and en moves
    // exactly when long_evt is high.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_mode    = mode;
            prev_en      = en;
            prev_pressed = pressed;
        end else begin
            if (mode_chg) begin
                chg_cnt++;
                last_chg_cyc = cyc;
            end
            if (long_evt) begin
                long_cnt++;
                last_long_cyc = cyc;
            end
            if (pressed && !prev_pressed) press_cnt++;
            if ((mode != prev_mode) || mode_chg)
                chk("mode_chg_align", int'(mode_chg), int'(mode != prev_mode));
            if ((en != prev_en) || long_evt)
                chk("long_evt_align", int'(long_evt), int'(en != prev_en));
            prev_mode    = mode;
            prev_en      = en;
            prev_pressed = pressed;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        int dur;        // cycles btn is held high
        int exp_mode;
        int exp_en;
        int exp_chg;    // mode_chg pulses produced by this press
        int exp_long;   // long_evt pulses produced by this press
        int exp_press;  // debounced rising edges produced by this press
    } vec_t;

    vec_t tbl[11];

    initial begin
        int c0, l0, p0, m0, rise_cyc, fall_cyc;

        checks = 0; errors = 0; cyc = 0;
        chg_cnt = 0; long_cnt = 0; press_cnt = 0;
        last_chg_cyc = 0; last_long_cyc = 0;
        prev_mode = '0; prev_en = 1'b0; prev_pressed = 1'b0;

        // The debounce pipeline delays both edges by the same amount, so the
        // debounced level is high exactly 'dur' cycles. HELD then sees the
        // counter at LONG_CYCLES-1 with the level still high only if dur >= 41.
        // At dur = 40 the release lands on that same cycle, and the release wins.
        tbl[0]  = '{20, 1, 1, 1, 0, 1};
        tbl[1]  = '{20, 2, 1, 1, 0, 1};
        tbl[2]  = '{20, 0, 1, 1, 0, 1};
        tbl[3]  = '{20, 1, 1, 1, 0, 1};
        tbl[4]  = '{80, 1, 0, 0, 1, 1};
        tbl[5]  = '{20, 1, 0, 0, 0, 1};
        tbl[6]  = '{80, 1, 1, 0, 1, 1};
        tbl[7]  = '{ 5, 1, 1, 0, 0, 0};
        tbl[8]  = '{40, 2, 1, 1, 0, 1};
        tbl[9]  = '{41, 2, 0, 0, 1, 1};
        tbl[10] = '{41, 2, 1, 0, 1, 1};

        // reset
        rstn = 1'b0;
        btn  = 1'b0;
        tick(3);
        chk("rst_mode", int'(mode), INI_MODE);
        chk("rst_en", int'(en), INI_EN);
        chk("rst_mode_chg", int'(mode_chg), 0);
        chk("rst_long_evt", int'(long_evt), 0);
        chk("rst_pressed", int'(pressed), 0);
        rstn = 1'b1;
        tick(5);

        // table of presses
        for (int i = 0; i < 11; i++) begin
            c0 = chg_cnt; l0 = long_cnt; p0 = press_cnt;
            btn = 1'b1;
            rise_cyc = cyc;
            tick(tbl[i].dur);
            btn = 1'b0;
            fall_cyc = cyc;
            tick(GAP);
            chk($sformatf("v%0d_mode", i), int'(mode), tbl[i].exp_mode);
            chk($sformatf("v%0d_en", i), int'(en), tbl[i].exp_en);
            chk($sformatf("v%0d_chg_pulses", i), chg_cnt - c0, tbl[i].exp_chg);
            chk($sformatf("v%0d_long_pulses", i), long_cnt - l0, tbl[i].exp_long);
            chk($sformatf("v%0d_press_edges", i), press_cnt - p0, tbl[i].exp_press);
            if (tbl[i].exp_chg == 1)
                chk_range($sformatf("v%0d_chg_latency", i), last_chg_cyc - fall_cyc, 10, 15);
            if (tbl[i].exp_long == 1)
                chk_range($sformatf("v%0d_long_latency", i), last_long_cyc - rise_cyc, 49, 56);
        end

        // bouncing press: 10 segments of 3 cycles, then a clean hold of 20
        c0 = chg_cnt; p0 = press_cnt; m0 = int'(mode);
        for (int s = 0; s < 10; s++) begin
            btn = (s % 2 == 0);
            tick(3);
        end
        btn = 1'b1;
        tick(20);
        btn = 1'b0;
        tick(GAP);
        chk("bounce_press_edges", press_cnt - p0, 1);
        chk("bounce_chg_pulses", chg_cnt - c0, 1);
        chk("bounce_mode", int'(mode), (m0 + 1) % NMODES);

        // make mode differ from INI_MODE, then reset asynchronously between edges
        btn = 1'b1;
        tick(20);
        btn = 1'b0;
        tick(GAP);
        chk("pre_async_mode", int'(mode), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_mode", int'(mode), INI_MODE);
        chk("async_rst_en", int'(en), INI_EN);
        chk("async_rst_pressed", int'(pressed), 0);
        tick(2);
        rstn = 1'b1;
        tick(5);

        // reset mid-press: the held button becomes a fresh press after reset
        btn = 1'b1;
        tick(20);
        btn = 1'b0;
        tick(GAP);
        chk("pre_midpress_mode", int'(mode), 1);
        c0 = chg_cnt;
        btn = 1'b1;
        tick(27);
        chk("midpress_pressed", int'(pressed), 1);
        #2;
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
        chk("midpress_rst_mode", int'(mode), INI_MODE);
        chk("midpress_rst_pressed", int'(pressed), 0);
        chk("midpress_rst_no_chg", chg_cnt - c0, 0);
        tick(30);
        chk("midpress_fresh_pressed", int'(pressed), 1);
        btn = 1'b0;
        tick(GAP);
        chk("midpress_fresh_mode", int'(mode), (INI_MODE + 1) % NMODES);
        chk("midpress_fresh_chg", chg_cnt - c0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
